// File: rtl/md_sequencer.sv
// md_sequencer
// Multi-cycle sequencer for the HI/LO multiply/divide resource in the E stage.
// It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO at a time and models a fixed
// latency for each operation. It also drives the D-stage stall request for
// HI/LO users while the unit is occupied.
//
// Ports
//   clk       in   1  clock; all state changes on the rising edge
//   reset     in   1  synchronous, active-low; clears all state
//   op_valid  in   1  E-stage instruction is an HI/LO operation this cycle
//   md_op     in   3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a         in   W  forwarded rs value
//   b         in   W  forwarded rt value
//   d_uses_md in   1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
//   busy      out  1  unit is running a multi-cycle operation
//   stall_req out  1  stall the D stage: d_uses_md & (busy | start)
//   start     out  1  a multiply/divide is accepted this cycle
//   done      out  1  one-cycle pulse in the cycle after HI/LO commit
//   hi        out  W  architectural HI
//   lo        out  W  architectural LO
//   proto_err out  1  sticky flag: an operation was issued while busy

module md_sequencer #(
    parameter int W       = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_valid,
    input  logic [2:0]   md_op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         d_uses_md,
    output logic         busy,
    output logic         stall_req,
    output logic         start,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         proto_err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   pend_hi_q, pend_hi_d;
    logic [W-1:0]   pend_lo_q, pend_lo_d;
    logic           pend_wr_q, pend_wr_d;
    logic           done_q, done_d;
    logic           proto_err_q, proto_err_d;

    logic [2*W-1:0]        prod_s, prod_u;
    logic                  div_ovf, div_zero;
    logic [W-1:0]          div_b;
    logic signed [W-1:0]   sdiv_a, sdiv_b;
    logic [W-1:0]          sq, sr, uq, ur;
    logic [W-1:0]          res_hi, res_lo;
    logic                  res_wr;

    // Result datapath. Both products are formed at 2W width from explicitly
    // extended operands, so the low 2W bits hold the exact signed/unsigned
    // product. A zero divisor, and the most-negative / -1 overflow case, are
    // replaced by a divisor of 1, so the divider never sees an undefined
    // input. Their results are then supplied separately.
    always_comb begin
        prod_u   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        prod_s   = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        div_zero = (b == '0);
        div_ovf  = (a == {1'b1, {(W-1){1'b0}}}) && (b == {W{1'b1}});
        div_b    = (div_zero || div_ovf) ? W'(1) : b;
        sdiv_a   = a;
        sdiv_b   = div_b;
        sq       = sdiv_a / sdiv_b;
        sr       = sdiv_a % sdiv_b;
        uq       = a / div_b;
        ur       = a % div_b;
        res_hi   = prod_s[2*W-1:W];
        res_lo   = prod_s[W-1:0];
        res_wr   = 1'b1;
        case (md_op)
            3'd1: begin
                res_hi = prod_u[2*W-1:W];
                res_lo = prod_u[W-1:0];
            end
            3'd2: begin
                res_hi = div_ovf ? '0 : sr;
                res_lo = div_ovf ? a : sq;
                res_wr = !div_zero;
            end
            3'd3: begin
                res_hi = ur;
                res_lo = uq;
                res_wr = !div_zero;
            end
            default: ;
        endcase
    end

    // Control. start includes the ~busy term. While busy, every issue is
    // refused and only raises the sticky protocol error. HI/LO therefore
    // hold their old values for the whole RUN period. pend_wr_q records a
    // divide by zero, so that the commit leaves HI/LO untouched while still
    // using the full latency and pulsing done.
    always_comb begin
        busy        = (state_q == RUN);
        start       = op_valid && (md_op <= 3'd3) && !busy;
        stall_req   = d_uses_md && (busy || start);
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_wr_d   = pend_wr_q;
        done_d      = 1'b0;
        proto_err_d = proto_err_q || (op_valid && busy);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = md_op[1] ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_wr_d = res_wr;
                end else if (op_valid && md_op == 3'd4) begin
                    hi_d = a;
                end else if (op_valid && md_op == 3'd5) begin
                    lo_d = a;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. An active-low reset in the middle of RUN aborts the
    // operation: the pending result is discarded and done is not pulsed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            pend_hi_q   <= '0;
            pend_lo_q   <= '0;
            pend_wr_q   <= 1'b0;
            done_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_wr_q   <= pend_wr_d;
            done_q      <= done_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer
// Self-checking bench for md_sequencer. Each accepted multiply/divide pushes
// its expected HI/LO pair onto a scoreboard queue. The monitor pops that
// pair when done pulses and compares it with the committed HI/LO. Expected
// values come from a small 64-bit reference model.

module tb_md_sequencer;

    localparam int W       = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic          clk;
    logic          reset;
    logic          op_valid;
    logic [2:0]    md_op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          d_uses_md;
    logic          busy;
    logic          stall_req;
    logic          start;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          proto_err;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        expQ[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] modelHi  = '0;
    logic [31:0] modelLo  = '0;

    md_sequencer #(.W(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .md_op     (md_op),
        .a         (a),
        .b         (b),
        .d_uses_md (d_uses_md),
        .busy      (busy),
        .stall_req (stall_req),
        .start     (start),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .proto_err (proto_err)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the committed HI/LO. It uses 64-bit arithmetic,
    // so the signed overflow corner cannot trap.
    function automatic void calcExpected(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                                         input logic [31:0] oldHi, input logic [31:0] oldLo,
                                         output logic [31:0] eh, output logic [31:0] el);
        longint      p, sa, sb, q, r;
        logic [63:0] pu;
        eh = oldHi;
        el = oldLo;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (op)
            3'd0: begin
                p  = sa * sb;
                eh = p[63:32];
                el = p[31:0];
            end
            3'd1: begin
                pu = {32'd0, av} * {32'd0, bv};
                eh = pu[63:32];
                el = pu[31:0];
            end
            3'd2: begin
                if (bv != 0) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    eh = r[31:0];
                    el = q[31:0];
                end
            end
            3'd3: begin
                if (bv != 0) begin
                    eh = av % bv;
                    el = av / bv;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one multiply/divide from IDLE and follow it through RUN. The
    // task checks start, the stall request, that HI/LO hold steady, and the
    // exact busy length. If injectAt >= 0, an MTLO is issued on that RUN
    // cycle. The task returns in the done cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                                 input logic useMd, input int injectAt);
        exp_t        e;
        int          n;
        int          lat;
        lat = op[1] ? DIV_LAT : MUL_LAT;
        calcExpected(op, av, bv, modelHi, modelLo, e.hi, e.lo);
        op_valid  = 1'b1;
        md_op     = op;
        a         = av;
        b         = bv;
        d_uses_md = useMd;
        #1;
        checkOutput("start", start, 1);
        checkOutput("stall_start", stall_req, useMd);
        expQ.push_back(e);
        step();
        op_valid = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            if (n == injectAt) begin
                op_valid = 1'b1;
                md_op    = 3'd5;
                a        = 32'hDEADBEEF;
            end else begin
                op_valid = 1'b0;
            end
            #1;
            checkOutput("stall_run", stall_req, useMd);
            checkOutput("hi_hold", hi, modelHi);
            checkOutput("lo_hold", lo, modelLo);
            n++;
            step();
        end
        op_valid = 1'b0;
        #1;
        checkOutput("busy_cycles", n, lat);
        checkOutput("stall_drop", stall_req, 0);
        modelHi   = e.hi;
        modelLo   = e.lo;
        d_uses_md = 1'b0;
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the updates.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_done", done, 0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sb_hi", hi, e.hi);
                checkOutput("sb_lo", lo, e.lo);
            end
        end
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset     = 1'b0;
        op_valid  = 1'b0;
        md_op     = 3'd7;
        a         = '0;
        b         = '0;
        d_uses_md = 1'b0;
        step();
        step();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_hi", hi, 0);
        checkOutput("rst_lo", lo, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_proto", proto_err, 0);
        reset = 1'b1;
        step();

        // Signed and unsigned multiply of the same operands.
        applyStimulus(3'd0, 32'hFFFFFFFF, 32'd2, 1'b1, -1);
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, -1);
        checkOutput("multu_hi", modelHi, 32'h00000001);
        checkOutput("multu_lo", modelLo, 32'hFFFFFFFE);

        // Signed divide with truncation; unsigned divide by zero keeps HI/LO.
        applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1, -1);
        applyStimulus(3'd3, 32'd7, 32'd0, 1'b0, -1);
        checkOutput("divu0_lo", modelLo, 32'hFFFFFFFD);

        // Divide overflow corner.
        applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1);

        // MTHI in IDLE, followed by a no-op issue.
        op_valid = 1'b1;
        md_op    = 3'd4;
        a        = 32'h00001234;
        #1;
        checkOutput("mthi_nostart", start, 0);
        step();
        op_valid = 1'b0;
        #1;
        checkOutput("mthi_hi", hi, 32'h00001234);
        checkOutput("mthi_busy", busy, 0);
        checkOutput("done_one_cycle", done, 0);
        modelHi  = 32'h00001234;
        op_valid = 1'b1;
        md_op    = 3'd6;
        step();
        op_valid = 1'b0;
        #1;
        checkOutput("nop_busy", busy, 0);
        checkOutput("nop_proto", proto_err, 0);
        checkOutput("nop_done", done, 0);

        // MTLO issued during RUN is refused and sets the sticky error.
        applyStimulus(3'd0, 32'h00000003, 32'hFFFFFFFB, 1'b1, 2);
        checkOutput("proto_set", proto_err, 1);

        // Random back-to-back operations, including a divide by zero.
        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 2) ? 32'd0 : ((i == 4) ? 32'($urandom_range(1, 50)) : $urandom);
            applyStimulus(rop, ra, rb, i[0], -1);
        end
        checkOutput("proto_sticky", proto_err, 1);

        // Synchronous reset in the middle of RUN aborts the operation.
        op_valid = 1'b1;
        md_op    = 3'd0;
        a        = 32'd9;
        b        = 32'd9;
        step();
        op_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_hi", hi, 0);
        checkOutput("midrst_lo", lo, 0);
        checkOutput("midrst_proto", proto_err, 0);
        for (int i = 0; i < 15; i++) begin
            step();
            checkOutput("midrst_nodone", done, 0);
        end

        step();
        checkOutput("sb_empty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
